// File: rtl/gb_axis_pixel_src_if.sv
`default_nettype none
// ============================================================================
//  Module      : gb_axis_pixel_src_if
//  Description : AXI4-Stream pixel bus (TDATA/TVALID/TREADY/TLAST) between
//                the pixel source and the Gaussian blur sink.
//                master : drives TDATA, TVALID, TLAST; samples TREADY
//                slave  : samples TDATA, TVALID, TLAST; drives TREADY
//  Revision    : 1.0 - initial release
// ============================================================================
interface gb_axis_pixel_src_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] TDATA;
    logic              TVALID;
    logic              TREADY;
    logic              TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface
`default_nettype wire

// File: rtl/gb_axis_pixel_src.sv
`default_nettype none
// ============================================================================
//  Module      : gb_axis_pixel_src
//  Description : AXI4-Stream pixel transmitter. Sends num_frames raster-order
//                frames of IMG_W x IMG_H pixels, ramp or LFSR pattern, with
//                TLAST on the last pixel of each frame.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - job request, sampled only in IDLE
//                mode            - 0 = ramp (x+y), 1 = LFSR
//                seed            - LFSR seed (0 is replaced by 0x01)
//                num_frames      - frames per job (0 = immediate done)
//                m_axis          - stream master (TDATA/TVALID/TREADY/TLAST)
//                busy            - high while sending
//                done            - one-cycle pulse at job end
//                beat_cnt        - accepted beats in the current frame
//  Options     : `define SRC_GAP_EN inserts one idle cycle after every
//                GAP_PERIOD accepted beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_axis_pixel_src #(
    parameter int IMG_W      = 488,
    parameter int IMG_H      = 648,
    parameter int DATA_W     = 8,
    parameter int GAP_PERIOD = 7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    input  wire logic           mode,
    input  wire logic [7:0]     seed,
    input  wire logic [7:0]     num_frames,
    gb_axis_pixel_src_if.master m_axis,
    output logic                busy,
    output logic                done,
    output logic [18:0]         beat_cnt
);

    localparam int c_X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_X_W-1:0] c_X_MAX = c_X_W'(IMG_W - 1);
    localparam logic [c_Y_W-1:0] c_Y_MAX = c_Y_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_X_W-1:0]   r_x;
    logic [c_Y_W-1:0]   r_y;
    logic [7:0]         r_frame_cnt;
    logic [7:0]         r_num_frames;
    logic [7:0]         r_lfsr;
    logic               r_mode;
    logic [18:0]        r_beat_cnt;

    logic               w_gap;
    logic               w_hs;
    logic               w_last;
    logic               w_last_frame;
    logic               w_start_job;
    logic [15:0]        w_xy_sum;
    logic [7:0]         w_pix;

    assign w_start_job  = (r_state == ST_IDLE) && start && (num_frames != 8'd0);
    // Handshake derived from registered state only, so TVALID never depends
    // combinationally on TREADY.
    assign w_hs         = (r_state == ST_SEND) && !w_gap && m_axis.TREADY;
    assign w_last       = (r_x == c_X_MAX) && (r_y == c_Y_MAX);
    assign w_last_frame = ({1'b0, r_frame_cnt} + 9'd1) == {1'b0, r_num_frames};
    assign w_xy_sum     = 16'(r_x) + 16'(r_y);
    assign w_pix        = r_mode ? r_lfsr : w_xy_sum[7:0];

    assign m_axis.TDATA = DATA_W'(w_pix);
    assign m_axis.TLAST = (r_state == ST_SEND) && w_last;
    assign beat_cnt     = r_beat_cnt;

`ifdef SRC_GAP_EN
    localparam int c_GAP_W = (GAP_PERIOD > 1) ? $clog2(GAP_PERIOD + 1) : 1;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_gap;

    // The gap flag is only raised by a handshake, so a pending beat held by
    // TREADY=0 is never withdrawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
            r_gap     <= 1'b0;
        end else if (w_start_job) begin
            r_gap_cnt <= '0;
            r_gap     <= 1'b0;
        end else if (w_hs) begin
            if (r_gap_cnt == c_GAP_W'(GAP_PERIOD - 1)) begin
                r_gap_cnt <= '0;
                r_gap     <= 1'b1;
            end else begin
                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                r_gap     <= 1'b0;
            end
        end else begin
            r_gap <= 1'b0;
        end
    end
    assign w_gap = r_gap;
`else
    logic w_unused_gap;
    assign w_unused_gap = (GAP_PERIOD != 0);
    assign w_gap        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        m_axis.TVALID = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (num_frames != 8'd0) ? ST_SEND : ST_DONE;
            end
            ST_SEND: begin
                busy          = 1'b1;
                m_axis.TVALID = !w_gap;
                if (!w_gap && m_axis.TREADY && w_last && w_last_frame)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_cnt  <= 8'd0;
            r_num_frames <= 8'd0;
            r_lfsr       <= 8'h01;
            r_mode       <= 1'b0;
            r_beat_cnt   <= 19'd0;
        end else if (w_start_job) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_cnt  <= 8'd0;
            r_num_frames <= num_frames;
            r_lfsr       <= (seed == 8'd0) ? 8'h01 : seed;
            r_mode       <= mode;
            r_beat_cnt   <= 19'd0;
        end else if (w_hs) begin
            // x^8+x^6+x^5+x^4+1, shift left, feedback from bits 7,5,4,3
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (r_x == c_X_MAX) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_MAX) ? '0 : r_y + c_Y_W'(1);
            end else begin
                r_x <= r_x + c_X_W'(1);
            end
            if (w_last) begin
                r_beat_cnt  <= 19'd0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
                r_beat_cnt  <= r_beat_cnt + 19'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gb_axis_pixel_src.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_axis_pixel_src
//  Description : Self-checking bench for gb_axis_pixel_src (4x3 frames).
//                Expected beats come from a frame/pixel-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_axis_pixel_src;

    localparam int c_W  = 4;
    localparam int c_H  = 3;
    localparam int c_GP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  seed;
    logic [7:0]  num_frames;
    logic        busy;
    logic        done;
    logic [18:0] beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         bc;
    } beat_t;

    beat_t exp_q[$];

    gb_axis_pixel_src_if #(.DATA_W(8)) axis ();

    gb_axis_pixel_src #(
        .IMG_W      (c_W),
        .IMG_H      (c_H),
        .DATA_W     (8),
        .GAP_PERIOD (c_GP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .num_frames (num_frames),
        .m_axis     (axis),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Reference: list every pixel of the job in raster order.
    task automatic build_model(input bit m, input logic [7:0] sd, input int nf);
        logic [7:0] lf;
        beat_t      b;
        exp_q.delete();
        lf = (sd == 8'd0) ? 8'h01 : sd;
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < c_H; y++)
                for (int x = 0; x < c_W; x++) begin
                    b.d    = m ? lf : 8'((x + y) % 256);
                    b.last = (x == c_W - 1) && (y == c_H - 1);
                    b.bc   = y * c_W + x;
                    exp_q.push_back(b);
                    lf = lfsr_step(lf);
                end
    endtask

    task automatic run_job(input bit m, input logic [7:0] sd, input logic [7:0] nf,
                           input int ready_pct, input int stall_at, input int stall_len,
                           input bit noise);
        int         total, cycles, accepted, stall_rem, done_cnt, exp_cycles, budget;
        bit         prev_stall, rdy;
        logic [7:0] prev_d;
        logic       prev_l;
        beat_t      b;
        build_model(m, sd, int'(nf));
        total     = exp_q.size();
        stall_rem = stall_len;
        @(negedge clk);
        start = 1'b1; mode = m; seed = sd; num_frames = nf;
        @(negedge clk);
        start = 1'b0; mode = ~m; seed = $urandom; num_frames = $urandom;
        if (nf == 8'd0) begin
            check_eq("zero_done", done, 1);
            check_eq("zero_valid", axis.TVALID, 0);
            check_eq("zero_busy", busy, 0);
            @(negedge clk);
            check_eq("zero_done_end", done, 0);
            check_eq("zero_valid_end", axis.TVALID, 0);
            return;
        end
        check_eq("first_valid", axis.TVALID, 1);
        cycles = 0; accepted = 0; done_cnt = 0; prev_stall = 0;
        prev_d = '0; prev_l = 1'b0;
        budget = 40 * total + 50;
        while (exp_q.size() > 0 && cycles < budget) begin
            if (done) done_cnt++;
            check_eq("busy_send", busy, 1);
            if (prev_stall) begin
                check_eq("hold_valid", axis.TVALID, 1);
                check_eq("hold_data", axis.TDATA, prev_d);
                check_eq("hold_last", axis.TLAST, prev_l);
            end
`ifndef SRC_GAP_EN
            check_eq("valid_cont", axis.TVALID, 1);
`endif
            if (accepted == stall_at && stall_rem > 0) begin
                rdy = 1'b0;
                stall_rem--;
            end else begin
                rdy = ($urandom % 100) < ready_pct;
            end
            axis.TREADY = rdy;
            prev_stall  = axis.TVALID && !rdy;
            prev_d      = axis.TDATA;
            prev_l      = axis.TLAST;
            if (axis.TVALID && rdy) begin
                b = exp_q.pop_front();
                check_eq($sformatf("data[%0d]", accepted), axis.TDATA, b.d);
                check_eq($sformatf("last[%0d]", accepted), axis.TLAST, b.last);
                check_eq($sformatf("beat_cnt[%0d]", accepted), beat_cnt, b.bc);
                accepted++;
            end
            start = noise && exp_q.size() > 0 && ($urandom % 6 == 0);
            if (start) begin
                mode = $urandom; seed = $urandom; num_frames = 8'($urandom_range(1, 9));
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (exp_q.size() > 0) check_eq("timeout_beats_left", exp_q.size(), 0);
        check_eq("done_pulse", done, 1);
        check_eq("done_valid", axis.TVALID, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_beat_cnt", beat_cnt, 0);
        check_eq("no_early_done", done_cnt, 0);
        if (ready_pct == 100 && stall_len == 0) begin
            exp_cycles = total;
`ifdef SRC_GAP_EN
            exp_cycles = total + (total - 1) / c_GP;
`endif
            check_eq("send_cycles", cycles, exp_cycles);
        end
        @(negedge clk);
        check_eq("done_once", done, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_valid"}, axis.TVALID, 0);
        check_eq({pfx, "_last"}, axis.TLAST, 0);
        check_eq({pfx, "_data"}, axis.TDATA, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_done"}, done, 0);
        check_eq({pfx, "_beat_cnt"}, beat_cnt, 0);
    endtask

    // Reset after six accepted beats, with start asserted alongside rst.
    task automatic run_abort();
        logic [7:0] lf;
        int         got, guard;
        lf = 8'($urandom_range(1, 255));
        @(negedge clk);
        start = 1'b1; mode = 1'b1; seed = lf; num_frames = 8'd2;
        axis.TREADY = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0; guard = 0;
        while (got < 6 && guard < 50) begin
            if (axis.TVALID) begin
                check_eq($sformatf("abort_data[%0d]", got), axis.TDATA, lf);
                lf = lfsr_step(lf);
                got++;
            end
            guard++;
            @(negedge clk);
        end
        if (got < 6) check_eq("abort_timeout", got, 6);
        check_eq("abort_pending_valid", axis.TVALID, 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_wins_valid", axis.TVALID, 0);
        check_eq("rst_wins_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = 8'd0; num_frames = 8'd0;
        axis.TREADY = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_job(1'b0, 8'd0, 8'd1, 100, -1, 0, 1'b0);     // ramp, one frame
        run_job(1'b0, 8'd0, 8'd1, 100, 4, 3, 1'b0);      // stall on beat 5
        run_job(1'b0, 8'd0, 8'd2, 100, -1, 0, 1'b0);     // back-to-back frames
        run_job(1'b1, 8'h00, 8'd1, 100, -1, 0, 1'b0);    // LFSR, zero seed
        run_job(1'b1, 8'hB5, 8'd1, 100, -1, 0, 1'b0);    // LFSR, seed 0xB5
        run_job(1'b0, 8'd0, 8'd0, 100, -1, 0, 1'b0);     // zero frames
        for (int i = 0; i < 4; i++)
            run_job(1'($urandom), 8'($urandom), 8'($urandom_range(1, 3)),
                    $urandom_range(40, 100), -1, 0, 1'b1);
        run_abort();
        run_job(1'b0, 8'd0, 8'd1, 100, -1, 0, 1'b0);     // clean restart after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
